// File: rtl/sdsu_bus_pkg.sv
// Shared types and constants for the SDSU bus slave: FSM state encoding,
// wait-counter width and byte-enable width helpers.
package sdsu_bus_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam int DATA_W_DEF = 32;
  localparam int BE_W       = DATA_W_DEF / 8;
  localparam int CNT_W      = 4;

  // Byte-enable width for a parametrised data width.
  function automatic int be_width(input int data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/sdsu_bus_slave_if.sv
// Request/ready bus between a master and the SDSU register-file slave.
interface sdsu_bus_slave_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) ();
  import sdsu_bus_pkg::*;

  localparam int BW = be_width(DATA_W);

  logic              req;
  logic              wr_en;
  logic              rd_en;
  logic [ADDR_W-1:0] w_adr;
  logic [DATA_W-1:0] w_data;
  logic [BW-1:0]     w_be;
  logic [ADDR_W-1:0] r_adr;
  logic [DATA_W-1:0] r_data;
  logic              ready;
  logic              err;

  modport master (
    output req, wr_en, rd_en, w_adr, w_data, w_be, r_adr,
    input  r_data, ready, err
  );

  modport slave (
    input  req, wr_en, rd_en, w_adr, w_data, w_be, r_adr,
    output r_data, ready, err
  );

endinterface

// File: rtl/sdsu_regfile.sv
// DEPTH x DATA_W register file: async clear, byte-enabled synchronous write,
// combinational read. Each byte lane is its own storage array.
module sdsu_regfile #(
  parameter int DEPTH  = 32,
  parameter int DATA_W = 32,
  parameter int IW     = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                we_i,
  input  logic [DATA_W/8-1:0] be_i,
  input  logic [IW-1:0]       wadr_i,
  input  logic [DATA_W-1:0]   wdata_i,
  input  logic [IW-1:0]       radr_i,
  output logic [DATA_W-1:0]   rdata_o
);

  generate
    for (genvar gi = 0; gi < DATA_W / 8; gi++) begin : g_lane
      logic [7:0] lane_q [DEPTH];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < DEPTH; i++) lane_q[i] <= '0;
        end else if (we_i && be_i[gi]) begin
          lane_q[wadr_i] <= wdata_i[8*gi +: 8];
        end
      end

      assign rdata_o[8*gi +: 8] = lane_q[radr_i];
    end
  endgenerate

endmodule

// File: rtl/sdsu_bus_slave.sv
// SDSU bus slave: captures a request, waits WAIT_CYCLES, answers with a
// one-cycle ready pulse; reads sample on RESP entry, writes commit on RESP exit.
module sdsu_bus_slave
  import sdsu_bus_pkg::*;
#(
  parameter int ADDR_W      = 5,
  parameter int DATA_W      = 32,
  parameter int DEPTH       = 32,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  sdsu_bus_slave_if.slave   bus
);

  localparam int BEW = be_width(DATA_W);
  localparam int IW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_A = (ADDR_W + 1)'(DEPTH);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               capture;
  logic               wr_en_q, rd_en_q, err_q;
  logic [ADDR_W-1:0]  w_adr_q, r_adr_q;
  logic [DATA_W-1:0]  w_data_q, r_data_q;
  logic [BEW-1:0]     w_be_q;
  logic [DATA_W-1:0]  rf_rdata;
  logic               w_oor, r_oor, enter_resp, in_resp;

  assign w_oor      = {1'b0, w_adr_q} >= DEPTH_A;
  assign r_oor      = {1'b0, r_adr_q} >= DEPTH_A;
  assign in_resp    = (state_q == RESP);
  assign enter_resp = (state_d == RESP);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.req) begin
          capture = 1'b1;
          if (WAIT_CYCLES > 0) begin
            state_d = WAIT;
            cnt_d   = CNT_W'(WAIT_CYCLES - 1);
          end else begin
            state_d = RESP;
          end
        end
      end
      WAIT: begin
        if (cnt_q == '0) state_d = RESP;
        else             cnt_d   = cnt_q - 1'b1;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      wr_en_q  <= 1'b0;
      rd_en_q  <= 1'b0;
      w_adr_q  <= '0;
      w_data_q <= '0;
      w_be_q   <= '0;
      r_adr_q  <= '0;
      r_data_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (capture) begin
        wr_en_q  <= bus.wr_en;
        rd_en_q  <= bus.rd_en;
        w_adr_q  <= bus.w_adr;
        w_data_q <= bus.w_data;
        w_be_q   <= bus.w_be;
        r_adr_q  <= bus.r_adr;
      end
      // Read is sampled before the write commits, so a collision returns old data.
      if (enter_resp) begin
        err_q <= (wr_en_q && w_oor) || (rd_en_q && r_oor);
        if (rd_en_q) r_data_q <= r_oor ? '0 : rf_rdata;
      end
    end
  end

  sdsu_regfile #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W),
    .IW     (IW)
  ) u_regfile (
    .clk     (clk),
    .rst_n   (rst_n),
    .we_i    (in_resp && wr_en_q && !w_oor),
    .be_i    (w_be_q),
    .wadr_i  (w_adr_q[IW-1:0]),
    .wdata_i (w_data_q),
    .radr_i  (r_adr_q[IW-1:0]),
    .rdata_o (rf_rdata)
  );

  assign bus.ready  = in_resp;
  assign bus.err    = in_resp & err_q;
  assign bus.r_data = r_data_q;

endmodule

// File: tb/tb_sdsu_bus_slave.sv
// Scoreboard bench for sdsu_bus_slave: driver pushes expected responses from a
// behavioural memory model; a negedge monitor pops and compares on ready.
module tb_sdsu_bus_slave;
  import sdsu_bus_pkg::*;

  localparam int AW    = 5;
  localparam int DW    = 32;
  localparam int DEPTH = 16;
  localparam int WC    = 2;
  localparam int BW    = DW / 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sdsu_bus_slave_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  sdsu_bus_slave #(
    .ADDR_W      (AW),
    .DATA_W      (DW),
    .DEPTH       (DEPTH),
    .WAIT_CYCLES (WC)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    int          cyc;
    logic [DW-1:0] rdata;
    logic        err;
    int          id;
  } exp_t;

  exp_t          sb[$];
  int            n_chk  = 0;
  int            n_pass = 0;
  int            cyc    = 0;
  int            t_free = 0;
  int            txn_id = 0;
  logic [DW-1:0] mem_m [DEPTH];
  logic [DW-1:0] last_rd;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
  endtask

  // Monitor: at every negedge, either a response is due or ready/err must be low.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        chk("ready_in_reset", {31'b0, bus.ready}, '0);
      end else if (sb.size() > 0 && sb[0].cyc == cyc) begin
        chk("ready_pulse", {31'b0, bus.ready}, 1);
        chk("r_data", bus.r_data, sb[0].rdata);
        chk("err", {31'b0, bus.err}, {31'b0, sb[0].err});
        $display("txn %0d @cyc %0d: r_data=%h err=%b ready=%b", sb[0].id, cyc,
                 bus.r_data, bus.err, bus.ready);
        void'(sb.pop_front());
      end else begin
        chk("ready_idle", {31'b0, bus.ready}, '0);
        chk("err_idle", {31'b0, bus.err}, '0);
      end
    end
  end

  task automatic scramble(input bit rand_req);
    bus.req    = rand_req ? 1'($urandom) : 1'b0;
    bus.wr_en  = 1'($urandom);
    bus.rd_en  = 1'($urandom);
    bus.w_adr  = AW'($urandom);
    bus.r_adr  = AW'($urandom);
    bus.w_data = $urandom;
    bus.w_be   = BW'($urandom);
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
    last_rd = '0;
  endtask

  // Issue one transaction in the first idle cycle after `gap` cycles of req=0.
  task automatic do_txn(input bit we, input bit re, input int wa, input logic [DW-1:0] wd,
                        input logic [BW-1:0] be, input int ra, input int gap);
    logic err_e;
    do begin
      @(negedge clk);
      if (cyc < t_free) scramble(1'b1);
    end while (cyc < t_free);
    repeat (gap) begin
      scramble(1'b0);
      @(negedge clk);
    end
    bus.req    = 1'b1;
    bus.wr_en  = we;
    bus.rd_en  = re;
    bus.w_adr  = AW'(wa);
    bus.w_data = wd;
    bus.w_be   = be;
    bus.r_adr  = AW'(ra);
    err_e = (we && wa >= DEPTH) || (re && ra >= DEPTH);
    if (re) last_rd = (ra < DEPTH) ? mem_m[ra] : '0;
    sb.push_back('{cyc: cyc + 1 + WC, rdata: last_rd, err: err_e, id: txn_id});
    txn_id++;
    if (we && wa < DEPTH)
      for (int b = 0; b < BW; b++)
        if (be[b]) mem_m[wa][8*b +: 8] = wd[8*b +: 8];
    t_free = cyc + 2 + WC;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int wa, ra;
    model_reset();
    bus.req = 1'b0; bus.wr_en = 1'b0; bus.rd_en = 1'b0;
    bus.w_adr = '0; bus.r_adr = '0; bus.w_data = '0; bus.w_be = '0;
    repeat (3) @(negedge clk);
    chk("rdata_reset", bus.r_data, '0);
    chk("ready_reset", {31'b0, bus.ready}, '0);
    rst_n = 1'b1;
    t_free = cyc + 1;

    // Basic write then read
    do_txn(1, 0, 1, 32'd7, 4'hF, 0, 0);
    do_txn(0, 1, 0, 32'd0, 4'h0, 1, 1);
    // Byte enables
    do_txn(1, 0, 2, 32'hAABBCCDD, 4'b0101, 0, 0);
    do_txn(0, 1, 0, 32'h0, 4'h0, 2, 0);
    // Read/write collision returns the old value
    do_txn(1, 0, 3, 32'd5, 4'hF, 0, 2);
    do_txn(1, 1, 3, 32'd9, 4'hF, 3, 0);
    do_txn(0, 1, 0, 32'h0, 4'h0, 3, 0);
    // Out-of-range write and read; write to 16 must not alias to 0
    do_txn(1, 0, 16, 32'hDEADBEEF, 4'hF, 0, 0);
    do_txn(0, 1, 0, 32'h0, 4'h0, 20, 0);
    do_txn(0, 1, 0, 32'h0, 4'h0, 0, 0);
    // Null transaction holds r_data
    do_txn(0, 0, 5, 32'h12345678, 4'hF, 5, 1);
    // Back-to-back with req held high
    do_txn(1, 0, 15, 32'h0BADF00D, 4'hF, 0, 0);
    do_txn(1, 1, 14, 32'h11223344, 4'hC, 15, 0);
    do_txn(0, 1, 0, 32'h0, 4'h0, 14, 0);

    // Reset during WAIT of a write of 1 to adr 0
    do_txn(1, 0, 0, 32'd1, 4'hF, 0, 0);
    @(negedge clk);
    rst_n = 1'b0;
    sb.delete();
    model_reset();
    bus.req = 1'b0;
    repeat (2) @(negedge clk);
    chk("rdata_after_abort", bus.r_data, '0);
    rst_n = 1'b1;
    t_free = cyc + 1;
    do_txn(0, 1, 0, 32'h0, 4'h0, 0, 0);

    // Randomised traffic, mostly in range
    for (int n = 0; n < 150; n++) begin
      wa = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 31) : $urandom_range(0, DEPTH - 1);
      ra = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 31) : $urandom_range(0, DEPTH - 1);
      do_txn(1'($urandom), 1'($urandom), wa, $urandom, BW'($urandom), ra,
             ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 3));
    end

    @(negedge clk);
    scramble(1'b0);
    repeat (WC + 4) @(negedge clk);
    chk("sb_drained", DW'(sb.size()), '0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
